// File: rtl/mips32_fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch front end.
package mips32_fetch_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0;
  localparam logic [31:0] PC_STEP_PAIR = 32'd8;
  localparam logic [31:0] PC_STEP_WORD = 32'd4;

  // One queued instruction together with its byte PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary; pair alignment is not required
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Instruction queue storage: two write ports at wr_ptr/wr_ptr+1 and two
// asynchronous read ports at rd_ptr/rd_ptr+1, so a whole pair moves per cycle.
module fetch_queue_ram
  import mips32_fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         i_we,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  fetch_entry_t i_wdata1,
  input  fetch_entry_t i_wdata2,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output fetch_entry_t o_rdata1,
  output fetch_entry_t o_rdata2
);

  fetch_entry_t r_mem [DEPTH];

  logic [PTR_W-1:0] w_wr_ptr2;
  logic [PTR_W-1:0] w_rd_ptr2;

  // Pointer arithmetic wraps naturally at the power-of-two depth
  assign w_wr_ptr2 = i_wr_ptr + 1'b1;
  assign w_rd_ptr2 = i_rd_ptr + 1'b1;

  // Pair write; storage carries no reset since validity is tracked by the count
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_wr_ptr]  <= i_wdata1;
      r_mem[w_wr_ptr2] <= i_wdata2;
    end
  end

  assign o_rdata1 = r_mem[i_rd_ptr];
  assign o_rdata2 = r_mem[w_rd_ptr2];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-issue fetch front end: fetch PC, paired ROM reads, circular pair queue
// with first-word-fall-through head, ID/EX redirect flush.
// Optional build macro FETCH_PERF_EN adds saturating performance counters;
// without it the perf_* ports read as zero.
module inst_fetch_buffer
  import mips32_fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          ROM_AW   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ROM_AW-1:0] ROM_A1,
  output logic [ROM_AW-1:0] ROM_A2,
  input  logic [31:0]       ROM_RD1,
  input  logic [31:0]       ROM_RD2,
  input  logic              id_set_pc,
  input  logic [31:0]       id_pc,
  input  logic              ex_set_pc,
  input  logic [31:0]       ex_pc,
  input  logic              hang,
  output logic              out_valid,
  output logic [31:0]       PC1,
  output logic [31:0]       PC2,
  output logic [31:0]       inst_1,
  output logic [31:0]       inst_2,
  output logic [31:0]       perf_full_cnt,
  output logic [31:0]       perf_empty_cnt,
  output logic [31:0]       perf_redir_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] PAIR_CNT   = CNT_W'(2);
  localparam logic [PTR_W-1:0] PAIR_PTR   = PTR_W'(2);

  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_last_pc1;
  logic [31:0]      r_last_pc2;

  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_push;
  logic             w_pop;
  logic             w_full_block;
  fetch_entry_t     w_wdata1;
  fetch_entry_t     w_wdata2;
  fetch_entry_t     w_head1;
  fetch_entry_t     w_head2;

  // EX redirect belongs to the older instruction, so it wins over ID
  assign w_redirect = ex_set_pc | id_set_pc;
  assign w_target   = align_word(ex_set_pc ? ex_pc : id_pc);

  // Push eligibility looks at the pre-pop count: no same-cycle full bypass
  assign w_full_block = (r_count > PUSH_LIMIT);
  assign w_push       = !w_redirect && !w_full_block;
  assign w_pop        = out_valid && !hang && !w_redirect;

  assign ROM_A1 = r_fetch_pc[ROM_AW+1:2];
  assign ROM_A2 = ROM_A1 + 1'b1;

  assign w_wdata1 = '{pc: r_fetch_pc,                inst: ROM_RD1};
  assign w_wdata2 = '{pc: r_fetch_pc + PC_STEP_WORD, inst: ROM_RD2};

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .CLK      (CLK),
    .i_we     (w_push && !RST),
    .i_wr_ptr (r_wr_ptr),
    .i_wdata1 (w_wdata1),
    .i_wdata2 (w_wdata2),
    .i_rd_ptr (r_rd_ptr),
    .o_rdata1 (w_head1),
    .o_rdata2 (w_head2)
  );

  // Head pair falls straight through from storage; empty queue shows NOPs
  assign out_valid = (r_count != '0);
  assign inst_1    = out_valid ? w_head1.inst : NOP_INST;
  assign inst_2    = out_valid ? w_head2.inst : NOP_INST;
  assign PC1       = out_valid ? w_head1.pc   : r_last_pc1;
  assign PC2       = out_valid ? w_head2.pc   : r_last_pc2;

  // Fetch PC, queue pointers and occupancy; redirect flushes and reloads the PC
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP_PAIR;
        r_wr_ptr   <= r_wr_ptr + PAIR_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PAIR_PTR;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PAIR_CNT;
        2'b01:   r_count <= r_count - PAIR_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember the most recently consumed PCs so PC1/PC2 hold while empty
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_pc1 <= '0;
      r_last_pc2 <= '0;
    end else if (w_pop) begin
      r_last_pc1 <= w_head1.pc;
      r_last_pc2 <= w_head2.pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_empty;
  logic [31:0] r_perf_redir;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters: full-blocked pushes, idle decode cycles, redirects
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_full  <= '0;
      r_perf_empty <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_full_block && !w_redirect) r_perf_full  <= sat_inc(r_perf_full);
      if (!out_valid && !hang)         r_perf_empty <= sat_inc(r_perf_empty);
      if (w_redirect)                  r_perf_redir <= sat_inc(r_perf_redir);
    end
  end

  assign perf_full_cnt  = r_perf_full;
  assign perf_empty_cnt = r_perf_empty;
  assign perf_redir_cnt = r_perf_redir;
`else
  assign perf_full_cnt  = 32'h0;
  assign perf_empty_cnt = 32'h0;
  assign perf_redir_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=8, ROM_AW=6, RESET_PC=0).
// ROM model: ROM[i] = 32'h1000_0000 + i.
module tb_inst_fetch_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  ROM_A1, ROM_A2;
  logic [31:0] ROM_RD1, ROM_RD2;
  logic        id_set_pc, ex_set_pc, hang;
  logic [31:0] id_pc, ex_pc;
  logic        out_valid;
  logic [31:0] PC1, PC2, inst_1, inst_2;
  logic [31:0] perf_full_cnt, perf_empty_cnt, perf_redir_cnt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign ROM_RD1 = 32'h1000_0000 + {26'b0, ROM_A1};
  assign ROM_RD2 = 32'h1000_0000 + {26'b0, ROM_A2};

  inst_fetch_buffer #(
    .DEPTH    (8),
    .ROM_AW   (6),
    .RESET_PC (32'h0)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ROM_A1         (ROM_A1),
    .ROM_A2         (ROM_A2),
    .ROM_RD1        (ROM_RD1),
    .ROM_RD2        (ROM_RD2),
    .id_set_pc      (id_set_pc),
    .id_pc          (id_pc),
    .ex_set_pc      (ex_set_pc),
    .ex_pc          (ex_pc),
    .hang           (hang),
    .out_valid      (out_valid),
    .PC1            (PC1),
    .PC2            (PC2),
    .inst_1         (inst_1),
    .inst_2         (inst_2),
    .perf_full_cnt  (perf_full_cnt),
    .perf_empty_cnt (perf_empty_cnt),
    .perf_redir_cnt (perf_redir_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; hang = 1'b0;
    id_set_pc = 1'b0; id_pc = 32'h0;
    ex_set_pc = 1'b0; ex_pc = 32'h0;
    tick(); tick();

    check("rst_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_inst1",  inst_1, 32'h0);
    check("rst_inst2",  inst_2, 32'h0);
    check("rst_pc1",    PC1, 32'h0);
    check("rst_pc2",    PC2, 32'h0);
    check("rst_a1",     {26'b0, ROM_A1}, 32'd0);
    check("rst_a2",     {26'b0, ROM_A2}, 32'd1);
    check("rst_pfull",  perf_full_cnt, 32'd0);

    // Streaming with no stall
    RST = 1'b0;
    tick();
    check("s1_valid", {31'b0, out_valid}, 32'd1);
    check("s1_pc1",   PC1, 32'h0);
    check("s1_inst1", inst_1, 32'h1000_0000);
    check("s1_pc2",   PC2, 32'h4);
    check("s1_inst2", inst_2, 32'h1000_0001);
    tick();
    check("s2_pc1",   PC1, 32'h8);
    check("s2_inst1", inst_1, 32'h1000_0002);
    tick();
    check("s3_pc1",   PC1, 32'h10);

    // Decode hang for 6 cycles: queue fills, fetch freezes at PC 0x30
    hang = 1'b1;
    tick();
    check("h1_pc1", PC1, 32'h10);
    tick(); tick(); tick();
    check("h4_a1",  {26'b0, ROM_A1}, 32'd12);
    tick(); tick();
    check("h6_a1",    {26'b0, ROM_A1}, 32'd12);
    check("h6_pc1",   PC1, 32'h10);
    check("h6_valid", {31'b0, out_valid}, 32'd1);
`ifdef FETCH_PERF_EN
    check("h6_pfull",  perf_full_cnt,  32'd3);
    check("h6_pempty", perf_empty_cnt, 32'd1);
    check("h6_predir", perf_redir_cnt, 32'd0);
`else
    check("h6_pfull",  perf_full_cnt,  32'd0);
    check("h6_pempty", perf_empty_cnt, 32'd0);
    check("h6_predir", perf_redir_cnt, 32'd0);
`endif

    // Release: sequence continues without gap or repeat
    hang = 1'b0;
    tick();
    check("r1_pc1",   PC1, 32'h18);
    check("r1_inst1", inst_1, 32'h1000_0006);
    check("r1_pc2",   PC2, 32'h1C);
    tick();
    check("r2_pc1",   PC1, 32'h20);
    check("r2_a1",    {26'b0, ROM_A1}, 32'd14);
    tick();
    check("r3_pc1",   PC1, 32'h28);

    // EX redirect to 0x20 with 6 queued
    ex_set_pc = 1'b1; ex_pc = 32'h20;
    tick();
    ex_set_pc = 1'b0;
    check("ex_valid", {31'b0, out_valid}, 32'd0);
    check("ex_inst1", inst_1, 32'h0);
    check("ex_inst2", inst_2, 32'h0);
    check("ex_a1",    {26'b0, ROM_A1}, 32'd8);
    check("ex_hold1", PC1, 32'h20);
    check("ex_hold2", PC2, 32'h24);
    tick();
    check("ex_pc1",   PC1, 32'h20);
    check("ex_i1",    inst_1, 32'h1000_0008);
    check("ex_pc2",   PC2, 32'h24);

    // Simultaneous ID and EX redirect: EX target wins
    id_set_pc = 1'b1; id_pc = 32'h40;
    ex_set_pc = 1'b1; ex_pc = 32'h10;
    tick();
    id_set_pc = 1'b0; ex_set_pc = 1'b0;
    check("pri_a1",    {26'b0, ROM_A1}, 32'd4);
    check("pri_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("pri_pc1",   PC1, 32'h10);
    check("pri_inst1", inst_1, 32'h1000_0004);

    // Odd-word target at top of ROM: address wraps, PC does not
    ex_set_pc = 1'b1; ex_pc = 32'hFC;
    tick();
    ex_set_pc = 1'b0;
    check("wr_a1", {26'b0, ROM_A1}, 32'd63);
    check("wr_a2", {26'b0, ROM_A2}, 32'd0);
    tick();
    check("wr_pc1",   PC1, 32'hFC);
    check("wr_inst1", inst_1, 32'h1000_003F);
    check("wr_pc2",   PC2, 32'h100);
    check("wr_inst2", inst_2, 32'h1000_0000);
    check("wr_next",  {26'b0, ROM_A1}, 32'd1);

    // Fill the queue under hang, then reset mid-operation
    hang = 1'b1;
    tick(); tick(); tick(); tick();
    check("f_a1",    {26'b0, ROM_A1}, 32'd7);
    check("f_pc1",   PC1, 32'hFC);
    RST = 1'b1;
    tick();
    check("mr_valid", {31'b0, out_valid}, 32'd0);
    check("mr_a1",    {26'b0, ROM_A1}, 32'd0);
    check("mr_inst1", inst_1, 32'h0);
    check("mr_pc1",   PC1, 32'h0);
    check("mr_pfull", perf_full_cnt, 32'd0);
    check("mr_pempt", perf_empty_cnt, 32'd0);
    check("mr_predr", perf_redir_cnt, 32'd0);
    RST = 1'b0; hang = 1'b0;
    tick();
    check("ar_valid", {31'b0, out_valid}, 32'd1);
    check("ar_pc1",   PC1, 32'h0);
    check("ar_inst1", inst_1, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
